scm_read_port_arbiter: RTL and testbench
========================================

SCM_READ_PORT_ARBITER -- requirements
Module: scm_read_port_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 8, number of 32b read requesters.
REQ-002 SHALL have parameter N_READ, default 4, number of register-file read ports.
REQ-003 SHALL have parameter WADDR_WIDTH, default 5, 128b line address width.
REQ-004 SHALL have parameter RADDR_WIDTH, default WADDR_WIDTH+2, 32b word address width.
REQ-005 SHALL have parameter RDATA_WIDTH, default 32, word width; line width fixed at 4*RDATA_WIDTH.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-008 SHALL have port req_i, input, N_REQ, per-requester read request.
REQ-009 SHALL have port addr_i, input, N_REQ x RADDR_WIDTH, per-requester word address.
REQ-010 SHALL have port gnt_o, output, N_REQ, combinational grant in the request cycle.
REQ-011 SHALL have port rvalid_o, output, N_REQ, registered read-data valid.
REQ-012 SHALL have port rdata_o, output, N_REQ x RDATA_WIDTH, read data, qualified by rvalid_o.
REQ-013 SHALL have port wr_req_i, input, 1, line write request, always accepted.
REQ-014 SHALL have port wr_addr_i, input, WADDR_WIDTH, line address.
REQ-015 SHALL have port wr_data_i, input, 4*RDATA_WIDTH, line data.
REQ-016 SHALL have ports ReadEnable (output, N_READ), ReadAddr (output, N_READ x RADDR_WIDTH) and ReadData (input, N_READ x RDATA_WIDTH), to the register file.
REQ-017 SHALL have ports WriteEnable (output, 1), WriteAddr (output, WADDR_WIDTH) and WriteData (output, 4*RDATA_WIDTH), to the register file.

Function
REQ-018 SHALL hold a round-robin pointer ptr (0..N_REQ-1) and scan requesters ptr, ptr+1, ... mod N_REQ each cycle.
REQ-019 SHALL grant the first min(N_READ, eligible count) eligible requesters in scan order; eligible = req_i set and not stalled (REQ-024).
REQ-020 SHALL map the i-th granted requester in scan order to read port i, driving ReadEnable[i]=1 and ReadAddr[i]=its addr_i; unused ports SHALL have ReadEnable=0.
REQ-021 SHALL, when at least one grant is issued, set ptr to (last granted index + 1) mod N_REQ at the clock edge; otherwise ptr SHALL hold.
REQ-022 SHALL register the requester-to-port map; one cycle after a grant, rvalid_o[k]=1 and rdata_o[k]=ReadData[port of k]; latency is exactly 1 cycle.
REQ-023 SHALL pass wr_req_i, wr_addr_i and wr_data_i combinationally to WriteEnable, WriteAddr and WriteData; writes never stall.
REQ-024 SHALL, with the stall feature compiled in, make a request ineligible when wr_req_i=1 and addr_i[RADDR_WIDTH-1:2]==wr_addr_i in the same cycle; the request then competes normally in the next cycle.
REQ-025 SHALL keep gnt_o[k]=0 and rvalid_o[k]=0 for requesters without req_i; a requester without a grant SHALL keep req_i and addr_i stable until granted.
REQ-026 SHALL, when req_i is all zero, drive all ReadEnable=0, leave ptr unchanged, and drive rvalid_o=0 in the next cycle.

Reset
REQ-027 SHALL, while rst=1 at a clock edge, set ptr=0, rvalid_o=0 and clear the port map, with rdata_o don't-care.
REQ-028 SHALL force gnt_o=0, ReadEnable=0 and WriteEnable=0 combinationally while rst=1.
REQ-029 SHALL discard reads granted in the cycle before reset is asserted: rvalid_o=0 after the reset edge.

Configuration
REQ-030 SHALL, when SCM_ARB_RAW_STALL_EN is defined, implement the same-line write/read stall of REQ-024.
REQ-031 SHALL, when SCM_ARB_RAW_STALL_EN is undefined, omit the stall; all requests are eligible, and same-cycle same-line read data is undefined.

Verification
REQ-032 SHALL cover: N_REQ=8, N_READ=4, req_i=0xFF for 2 cycles after reset -> gnt 0x0F then 0xF0, with rvalid one cycle after each grant.
REQ-033 SHALL cover: write line 3 = {D,C,B,A}, then 2 cycles later req_i[5]=1 with addr=13 -> rdata_o[5]=B with rvalid_o[5]=1 one cycle after the grant.
REQ-034 SHALL cover, with SCM_ARB_RAW_STALL_EN defined: wr_req_i=1 with wr_addr_i=2 and req_i[0]=1 with addr=9 in the same cycle -> gnt_o[0]=0, then gnt_o[0]=1 in the next cycle and the new data is returned.
REQ-035 SHALL cover: ptr=6 with req_i=0x41 -> gnt 0x41 in port order 6 then 0, and ptr becomes 1.
REQ-036 SHALL cover: rst asserted in the cycle after a grant -> rvalid_o=0 and ptr=0 after the reset edge.
REQ-037 SHALL cover: req_i=0 for 3 cycles -> ReadEnable=0, rvalid_o=0 and ptr unchanged throughout.

Source files
------------

// File: rtl/scm_read_port_arbiter.sv
// Round-robin arbiter mapping N_REQ word readers onto N_READ register-file read ports,
// with a pass-through line write port. Define SCM_ARB_RAW_STALL_EN to stall same-line reads during a write.
`timescale 1ns/1ps

module scm_read_port_arbiter #(
    parameter int N_REQ       = 8,
    parameter int N_READ      = 4,
    parameter int WADDR_WIDTH = 5,
    parameter int RADDR_WIDTH = WADDR_WIDTH + 2,
    parameter int RDATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_i,
    input  logic [N_REQ*RADDR_WIDTH-1:0]  addr_i,
    output logic [N_REQ-1:0]              gnt_o,
    output logic [N_REQ-1:0]              rvalid_o,
    output logic [N_REQ*RDATA_WIDTH-1:0]  rdata_o,
    input  logic                          wr_req_i,
    input  logic [WADDR_WIDTH-1:0]        wr_addr_i,
    input  logic [4*RDATA_WIDTH-1:0]      wr_data_i,
    output logic [N_READ-1:0]             ReadEnable,
    output logic [N_READ*RADDR_WIDTH-1:0] ReadAddr,
    input  logic [N_READ*RDATA_WIDTH-1:0] ReadData,
    output logic                          WriteEnable,
    output logic [WADDR_WIDTH-1:0]        WriteAddr,
    output logic [4*RDATA_WIDTH-1:0]      WriteData
);

    localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PORT_W = (N_READ > 1) ? $clog2(N_READ) : 1;
    localparam int CNT_W  = $clog2(N_READ + 1);

    logic [RADDR_WIDTH-1:0] addr_s      [N_REQ];
    logic [RDATA_WIDTH-1:0] port_data_s [N_READ];
    logic [RADDR_WIDTH-1:0] read_addr_s [N_READ];
    logic [PORT_W-1:0]      map_s       [N_REQ];
    logic [PORT_W-1:0]      map_r       [N_REQ];
    logic [N_REQ-1:0]       elig_s;
    logic [N_REQ-1:0]       gnt_s;
    logic [N_REQ-1:0]       vld_r;
    logic [N_READ-1:0]      read_en_s;
    logic [PTR_W-1:0]       ptr_r;
    logic [PTR_W-1:0]       last_s;
    logic [PTR_W-1:0]       ptr_next_s;
    logic                   any_s;

    for (genvar k = 0; k < N_REQ; k++) begin : g_req
        assign addr_s[k] = addr_i[k*RADDR_WIDTH +: RADDR_WIDTH];
        assign rdata_o[k*RDATA_WIDTH +: RDATA_WIDTH] = port_data_s[map_r[k]];
    end

    for (genvar p = 0; p < N_READ; p++) begin : g_port
        assign port_data_s[p] = ReadData[p*RDATA_WIDTH +: RDATA_WIDTH];
        assign ReadAddr[p*RADDR_WIDTH +: RADDR_WIDTH] = read_addr_s[p];
    end

    // Eligibility: a read of the line being written this cycle waits one cycle when the stall is built in.
    always_comb begin
        elig_s = '0;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef SCM_ARB_RAW_STALL_EN
            elig_s[k] = req_i[k] & ~(wr_req_i & (addr_s[k][RADDR_WIDTH-1:2] == wr_addr_i));
`else
            elig_s[k] = req_i[k];
`endif
        end
    end

    // Round-robin scan from ptr_r; the i-th granted requester takes read port i.
    always_comb begin : scan_comb
        logic [PTR_W:0]   sum_v;
        logic [PTR_W-1:0] idx_v;
        logic [CNT_W-1:0] cnt_v;
        gnt_s     = '0;
        read_en_s = '0;
        last_s    = ptr_r;
        any_s     = 1'b0;
        sum_v     = '0;
        idx_v     = '0;
        cnt_v     = '0;
        for (int p = 0; p < N_READ; p++) begin
            read_addr_s[p] = '0;
        end
        for (int k = 0; k < N_REQ; k++) begin
            map_s[k] = '0;
        end
        for (int j = 0; j < N_REQ; j++) begin
            sum_v = {1'b0, ptr_r} + (PTR_W+1)'(j);
            if (sum_v >= (PTR_W+1)'(N_REQ)) begin
                sum_v = sum_v - (PTR_W+1)'(N_REQ);
            end else begin
                sum_v = sum_v;
            end
            idx_v = sum_v[PTR_W-1:0];
            if (elig_s[idx_v] && (cnt_v < CNT_W'(N_READ))) begin
                gnt_s[idx_v] = 1'b1;
                map_s[idx_v] = cnt_v[PORT_W-1:0];
                for (int p = 0; p < N_READ; p++) begin
                    read_en_s[p]   = read_en_s[p] | (cnt_v == CNT_W'(p));
                    read_addr_s[p] = (cnt_v == CNT_W'(p)) ? addr_s[idx_v] : read_addr_s[p];
                end
                last_s = idx_v;
                any_s  = 1'b1;
                cnt_v  = cnt_v + CNT_W'(1);
            end else begin
                cnt_v = cnt_v;
            end
        end
    end

    assign ptr_next_s = (last_s == PTR_W'(N_REQ - 1)) ? '0 : last_s + PTR_W'(1);

    // Pointer advance and requester-to-port map for the one-cycle read return.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
            vld_r <= '0;
            for (int k = 0; k < N_REQ; k++) begin
                map_r[k] <= '0;
            end
        end else begin
            if (any_s) begin
                ptr_r <= ptr_next_s;
            end else begin
                ptr_r <= ptr_r;
            end
            vld_r <= gnt_s;
            for (int k = 0; k < N_REQ; k++) begin
                map_r[k] <= map_s[k];
            end
        end
    end

    assign gnt_o       = rst ? '0 : gnt_s;
    assign ReadEnable  = rst ? '0 : read_en_s;
    assign rvalid_o    = vld_r;
    assign WriteEnable = wr_req_i & ~rst;
    assign WriteAddr   = wr_addr_i;
    assign WriteData   = wr_data_i;

endmodule

// File: tb/tb_scm_read_port_arbiter.sv
// Directed bench for scm_read_port_arbiter with a behavioural one-cycle-latency register file.
`timescale 1ns/1ps

module tb_scm_read_port_arbiter;

    localparam int NR  = 8;
    localparam int NP  = 4;
    localparam int WAW = 5;
    localparam int AW  = 7;
    localparam int DW  = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic [NR-1:0]      req;
    logic [NR*AW-1:0]   addr;
    logic [NR-1:0]      gnt;
    logic [NR-1:0]      rvalid;
    logic [NR*DW-1:0]   rdata;
    logic               wr_req;
    logic [WAW-1:0]     wr_addr;
    logic [4*DW-1:0]    wr_data;
    logic [NP-1:0]      ren;
    logic [NP*AW-1:0]   raddr;
    logic [NP*DW-1:0]   rdat;
    logic               wen;
    logic [WAW-1:0]     waddr;
    logic [4*DW-1:0]    wdat;

    logic [AW-1:0]      addr_a [NR];
    logic [4*DW-1:0]    mem    [32];
    logic [31:0]        mem_v;
    logic [DW-1:0]      rdq    [NP];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NR; k++) begin : g_a
        assign addr[k*AW +: AW] = addr_a[k];
    end
    for (genvar p = 0; p < NP; p++) begin : g_d
        assign rdat[p*DW +: DW] = rdq[p];
    end

    scm_read_port_arbiter #(
        .N_REQ(NR), .N_READ(NP), .WADDR_WIDTH(WAW), .RADDR_WIDTH(AW), .RDATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst), .req_i(req), .addr_i(addr), .gnt_o(gnt),
        .rvalid_o(rvalid), .rdata_o(rdata), .wr_req_i(wr_req), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .ReadEnable(ren), .ReadAddr(raddr), .ReadData(rdat),
        .WriteEnable(wen), .WriteAddr(waddr), .WriteData(wdat)
    );

    // Register file model: unwritten words read back as 0xA0000000 | word address.
    always @(posedge clk) begin
        if (rst) begin
            mem_v <= '0;
        end else if (wen) begin
            mem[waddr]   <= wdat;
            mem_v[waddr] <= 1'b1;
        end
        for (int p = 0; p < NP; p++) begin
            if (ren[p]) begin
                if (mem_v[raddr[p*AW+2 +: WAW]])
                    rdq[p] <= mem[raddr[p*AW+2 +: WAW]][raddr[p*AW +: 2]*DW +: DW];
                else
                    rdq[p] <= 32'hA000_0000 | 32'(raddr[p*AW +: AW]);
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] rp(input int p);
        return raddr[p*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] rd(input int k);
        return rdata[k*DW +: DW];
    endfunction

    initial begin
        rst = 1'b1; req = '0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        for (int k = 0; k < NR; k++) addr_a[k] = '0;

        // Reset gating of grants and enables
        @(negedge clk); req = 8'hFF; wr_req = 1'b1; #1;
        chk("rst_gnt", 128'(gnt), 128'h0);
        chk("rst_ren", 128'(ren), 128'h0);
        chk("rst_wen", 128'(wen), 128'h0);

        @(negedge clk); rst = 1'b0; req = '0; wr_req = 1'b0;
        for (int k = 0; k < NR; k++) addr_a[k] = 7'(16 + k);
        #1;
        chk("rst_rvalid", 128'(rvalid), 128'h0);
        chk("rst_ptr", 128'(dut.ptr_r), 128'h0);

        // All eight request for two cycles
        @(negedge clk); req = 8'hFF; #1;
        chk("ff_gnt1", 128'(gnt), 128'h0F);
        chk("ff_ren1", 128'(ren), 128'hF);
        chk("ff_ra0", 128'(rp(0)), 128'd16);
        chk("ff_ra3", 128'(rp(3)), 128'd19);
        @(negedge clk); #1;
        chk("ff_gnt2", 128'(gnt), 128'hF0);
        chk("ff_ra0b", 128'(rp(0)), 128'd20);
        chk("ff_rv1", 128'(rvalid), 128'h0F);
        chk("ff_rd0", 128'(rd(0)), 128'hA000_0010);
        chk("ff_rd3", 128'(rd(3)), 128'hA000_0013);
        @(negedge clk); req = '0; #1;
        chk("ff_gnt3", 128'(gnt), 128'h0);
        chk("ff_rv2", 128'(rvalid), 128'hF0);
        chk("ff_rd5", 128'(rd(5)), 128'hA000_0015);

        // Idle cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("idle_ren", 128'(ren), 128'h0);
            chk("idle_rv", 128'(rvalid), 128'h0);
            chk("idle_ptr", 128'(dut.ptr_r), 128'h0);
        end

        // Line write then word read two cycles later
        @(negedge clk); wr_req = 1'b1; wr_addr = 5'd3;
        wr_data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}; #1;
        chk("wr_en", 128'(wen), 128'h1);
        chk("wr_addr", 128'(waddr), 128'h3);
        chk("wr_data", wdat, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111});
        @(negedge clk); wr_req = 1'b0;
        @(negedge clk); req = 8'h20; addr_a[5] = 7'd13; #1;
        chk("wr_gnt", 128'(gnt), 128'h20);
        chk("wr_ra0", 128'(rp(0)), 128'd13);
        @(negedge clk); req = '0; #1;
        chk("wr_rv", 128'(rvalid), 128'h20);
        chk("wr_rd5", 128'(rd(5)), 128'h2222_2222);
        chk("wr_ptr", 128'(dut.ptr_r), 128'h6);

        // Wraparound from ptr 6
        @(negedge clk); req = 8'h41; addr_a[6] = 7'd40; addr_a[0] = 7'd41; #1;
        chk("wrap_gnt", 128'(gnt), 128'h41);
        chk("wrap_ren", 128'(ren), 128'h3);
        chk("wrap_ra0", 128'(rp(0)), 128'd40);
        chk("wrap_ra1", 128'(rp(1)), 128'd41);
        @(negedge clk); req = '0; #1;
        chk("wrap_rv", 128'(rvalid), 128'h41);
        chk("wrap_rd6", 128'(rd(6)), 128'hA000_0028);
        chk("wrap_rd0", 128'(rd(0)), 128'hA000_0029);
        chk("wrap_ptr", 128'(dut.ptr_r), 128'h1);

        // Reset right after a grant
        @(negedge clk); req = 8'h02; addr_a[1] = 7'd5; #1;
        chk("rg_gnt", 128'(gnt), 128'h02);
        @(negedge clk); req = '0; rst = 1'b1;
        @(negedge clk); rst = 1'b0; req = 8'h55;
        for (int k = 0; k < NR; k++) addr_a[k] = 7'(16 + k);
        #1;
        chk("rg_rv", 128'(rvalid), 128'h0);
        chk("rg_ptr", 128'(dut.ptr_r), 128'h0);
        chk("p55_gnt", 128'(gnt), 128'h55);
        @(negedge clk); req = 8'hFF; #1;
        chk("p55_rv", 128'(rvalid), 128'h55);
        chk("p55_rd6", 128'(rd(6)), 128'hA000_0016);
        chk("p55_rd2", 128'(rd(2)), 128'hA000_0012);
        chk("p55_ptr", 128'(dut.ptr_r), 128'h7);
        chk("p7_gnt", 128'(gnt), 128'h87);
        chk("p7_ra0", 128'(rp(0)), 128'd23);
        chk("p7_ra1", 128'(rp(1)), 128'd16);
        @(negedge clk); req = '0; #1;
        chk("p7_rv", 128'(rvalid), 128'h87);
        chk("p7_rd7", 128'(rd(7)), 128'hA000_0017);
        chk("p7_ptr", 128'(dut.ptr_r), 128'h3);

`ifdef SCM_ARB_RAW_STALL_EN
        // Same-line write stalls the read for one cycle
        @(negedge clk); wr_req = 1'b1; wr_addr = 5'd2;
        wr_data = {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};
        req = 8'h01; addr_a[0] = 7'd9; #1;
        chk("st_gnt0", 128'(gnt), 128'h0);
        @(negedge clk); wr_req = 1'b0; #1;
        chk("st_ptr", 128'(dut.ptr_r), 128'h3);
        chk("st_gnt1", 128'(gnt), 128'h01);
        chk("st_ra0", 128'(rp(0)), 128'd9);
        @(negedge clk); req = '0; #1;
        chk("st_rv", 128'(rvalid), 128'h01);
        chk("st_rd0", 128'(rd(0)), 128'hDEAD_0001);
`endif

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
